// File: rtl/regfile_mp.sv
// Multi-port integer register file with a per-register busy scoreboard.
// x0 is hardwired to zero; optional same-cycle write-to-read forwarding.
module regfile_mp #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NREG   = 32,
  parameter int unsigned NR     = 2,
  parameter int unsigned NW     = 1,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NW-1:0]    wen,
  input  logic [NW*AW-1:0] wr_idx,
  input  logic [NW*XLEN-1:0] wr_data,
  input  logic [NR*AW-1:0] rd_idx,
  output logic [NR*XLEN-1:0] rd_data,
  output logic [NR-1:0]    rd_busy,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_idx,
  output logic             wr_conflict
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic            conflict_nxt;

  // Index 0 and indices beyond NREG are neither stored, reserved nor read.
  function automatic logic live_idx(input logic [AW-1:0] idx);
    return (idx != '0) && (32'(idx) < NREG);
  endfunction

  // Ascending port order lets the highest-numbered colliding port win; the
  // issue assignment follows the writeback clear so a new producer keeps busy set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      busy        <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NW; k++) begin
        if (wen[k] && live_idx(wr_idx[k*AW +: AW])) begin
          regs[wr_idx[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
          busy[wr_idx[k*AW +: AW]] <= 1'b0;
        end
      end
      if (iss_valid && live_idx(iss_idx)) busy[iss_idx] <= 1'b1;
      wr_conflict <= conflict_nxt;
    end
  end

  always_comb begin
    conflict_nxt = 1'b0;
    for (int unsigned k = 0; k < NW; k++) begin
      for (int unsigned m = k + 1; m < NW; m++) begin
        if (wen[k] && wen[m] && (wr_idx[k*AW +: AW] == wr_idx[m*AW +: AW]) &&
            (wr_idx[k*AW +: AW] != '0))
          conflict_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned j = 0; j < NR; j++) begin
      if (live_idx(rd_idx[j*AW +: AW])) begin
        rd_data[j*XLEN +: XLEN] = regs[rd_idx[j*AW +: AW]];
        rd_busy[j]              = busy[rd_idx[j*AW +: AW]];
        if (BYPASS) begin
          for (int unsigned k = 0; k < NW; k++) begin
            if (wen[k] && (wr_idx[k*AW +: AW] == rd_idx[j*AW +: AW])) begin
              rd_data[j*XLEN +: XLEN] = wr_data[k*XLEN +: XLEN];
              rd_busy[j] = iss_valid && (iss_idx == rd_idx[j*AW +: AW]);
            end
          end
        end
      end
    end
  end

endmodule
